// File: rtl/rename_pkg.sv
// Shared rename definitions: tag/pointer widths and modular pointer arithmetic.
// The map table also imports this package.
package rename_pkg;

  localparam int ARCH_COUNT      = 32;
  localparam int VIRT_COUNT      = 128;
  localparam int VIRT_ADDR_WIDTH = $clog2(VIRT_COUNT);
  localparam int ALLOC_PORTS     = 4;
  localparam int FREE_PORTS      = 4;
  localparam int DEPTH           = VIRT_COUNT - ARCH_COUNT;
  localparam int PTR_WIDTH       = $clog2(DEPTH);
  localparam int CNT_WIDTH       = $clog2(DEPTH + 1);

  typedef logic [VIRT_ADDR_WIDTH-1:0] virt_tag_t;
  typedef logic [PTR_WIDTH-1:0]       ptr_t;
  typedef logic [CNT_WIDTH-1:0]       cnt_t;

  // DEPTH is not a power of two, so wrap explicitly. A delta is at most
  // 2^CNT_WIDTH-1 < 2*DEPTH, so two corrections always suffice.
  function automatic ptr_t ptr_add(input ptr_t ptr, input int delta);
    int sum;
    sum = int'(ptr) + delta;
    if (sum >= DEPTH) sum = sum - DEPTH;
    if (sum >= DEPTH) sum = sum - DEPTH;
    return ptr_t'(sum);
  endfunction

  function automatic ptr_t ptr_sub(input ptr_t ptr, input int delta);
    int diff;
    diff = int'(ptr) - delta;
    if (diff < 0) diff = diff + DEPTH;
    if (diff < 0) diff = diff + DEPTH;
    return ptr_t'(diff);
  endfunction

endpackage

// File: rtl/prefix_popcount.sv
// Per-bit exclusive prefix popcount of a mask plus its total; used to compact
// sparse request/valid masks onto consecutive FIFO slots.
module prefix_popcount #(
  parameter int N  = 4,
  parameter int CW = $clog2(N + 1)
) (
  input  logic [N-1:0]    mask,
  output logic [N*CW-1:0] prefix,
  output logic [CW-1:0]   total
);

  always_comb begin
    logic [CW-1:0] acc;
    // NOTE: blocking '=' here so acc acts as a running sum within one evaluation.
    acc    = '0;
    prefix = '0;
    for (int i = 0; i < N; i++) begin
      prefix[i*CW +: CW] = acc;
      acc = acc + CW'(mask[i]);
    end
    total = acc;
  end

endmodule

// File: rtl/rename_free_list.sv
// Circular free list of virtual register tags: multi-port all-or-nothing
// allocation, multi-port return from commit, and squash rewind of the head.
module rename_free_list
  import rename_pkg::*;
(
  input  logic                                   clk,
  input  logic                                   async_rst,
  input  logic                                   clk_en,
  input  logic [ALLOC_PORTS-1:0]                 alloc_req,
  output logic                                   alloc_gnt,
  output logic [ALLOC_PORTS*VIRT_ADDR_WIDTH-1:0] alloc_tag,
  input  logic [FREE_PORTS-1:0]                  free_en,
  input  logic [FREE_PORTS*VIRT_ADDR_WIDTH-1:0]  free_tag,
  input  logic                                   squash_en,
  input  logic [CNT_WIDTH-1:0]                   squash_cnt,
  output logic [CNT_WIDTH-1:0]                   free_count,
  output logic                                   overflow_err
);

  localparam int AW = $clog2(ALLOC_PORTS + 1);
  localparam int FW = $clog2(FREE_PORTS + 1);
  localparam int W  = VIRT_ADDR_WIDTH;

  virt_tag_t storage [DEPTH];
  ptr_t      head, tail, head_nxt, tail_nxt;
  cnt_t      count_nxt;
  logic      ovf_now;
  ptr_t      free_idx [FREE_PORTS];

  logic [ALLOC_PORTS*AW-1:0] alloc_pre;
  logic [AW-1:0]             n_req;
  logic [FREE_PORTS*FW-1:0]  free_pre;
  logic [FW-1:0]             n_free;

  prefix_popcount #(.N(ALLOC_PORTS), .CW(AW)) u_alloc_pc (
    .mask   (alloc_req),
    .prefix (alloc_pre),
    .total  (n_req)
  );

  prefix_popcount #(.N(FREE_PORTS), .CW(FW)) u_free_pc (
    .mask   (free_en),
    .prefix (free_pre),
    .total  (n_free)
  );

  // Grant looks only at the registered count: same-cycle frees are not usable.
  assign alloc_gnt = clk_en & ~squash_en & ~async_rst & (n_req != '0) &
                     (int'(free_count) >= int'(n_req));

  always_comb begin
    alloc_tag = '0;
    for (int i = 0; i < ALLOC_PORTS; i++) begin
      alloc_tag[i*W +: W] = storage[ptr_add(head, int'(alloc_pre[i*AW +: AW]))];
    end
  end

  always_comb begin
    int sum;
    sum = int'(free_count) + int'(n_free)
        + (squash_en ? int'(squash_cnt) : 0)
        - (alloc_gnt ? int'(n_req) : 0);
    ovf_now   = clk_en & (sum > DEPTH);
    head_nxt  = head;
    tail_nxt  = tail;
    count_nxt = free_count;
    for (int j = 0; j < FREE_PORTS; j++) begin
      free_idx[j] = ptr_add(tail, int'(free_pre[j*FW +: FW]));
    end
    if (clk_en) begin
      if (alloc_gnt) head_nxt = ptr_add(head, int'(n_req));
      // On overflow the frees and the squash are discarded; allocation still lands.
      if (ovf_now) begin
        count_nxt = cnt_t'(int'(free_count) - (alloc_gnt ? int'(n_req) : 0));
      end else begin
        count_nxt = cnt_t'(sum);
        tail_nxt  = ptr_add(tail, int'(n_free));
        if (squash_en) head_nxt = ptr_sub(head, int'(squash_cnt));
      end
    end
  end

  // NOTE: storage is reset because its initial contents are the architectural
  // free list itself; this keeps it in flops rather than a RAM macro.
  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      head         <= '0;
      tail         <= '0;
      free_count   <= cnt_t'(DEPTH);
      overflow_err <= 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
        storage[k] <= virt_tag_t'(ARCH_COUNT + k);
      end
    end else if (clk_en) begin
      // NOTE: non-blocking '<=' so every update here sees the pre-edge state.
      head         <= head_nxt;
      tail         <= tail_nxt;
      free_count   <= count_nxt;
      overflow_err <= overflow_err | ovf_now;
      if (!ovf_now) begin
        for (int j = 0; j < FREE_PORTS; j++) begin
          if (free_en[j]) storage[free_idx[j]] <= free_tag[j*W +: W];
        end
      end
    end
  end

endmodule

// File: tb/tb_rename_free_list.sv
// Self-checking bench for rename_free_list: directed vector table, corner
// sequences, and a queue-based reference model of the free list.
module tb_rename_free_list;
  import rename_pkg::*;

  localparam int W = VIRT_ADDR_WIDTH;

  logic                 clk = 1'b0;
  logic                 async_rst;
  logic                 clk_en;
  logic [3:0]           alloc_req;
  logic                 alloc_gnt;
  logic [4*W-1:0]       alloc_tag;
  logic [3:0]           free_en;
  logic [4*W-1:0]       free_tag;
  logic                 squash_en;
  logic [CNT_WIDTH-1:0] squash_cnt;
  logic [CNT_WIDTH-1:0] free_count;
  logic                 overflow_err;

  rename_free_list dut (
    .clk          (clk),
    .async_rst    (async_rst),
    .clk_en       (clk_en),
    .alloc_req    (alloc_req),
    .alloc_gnt    (alloc_gnt),
    .alloc_tag    (alloc_tag),
    .free_en      (free_en),
    .free_tag     (free_tag),
    .squash_en    (squash_en),
    .squash_cnt   (squash_cnt),
    .free_count   (free_count),
    .overflow_err (overflow_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: fl is the ordered free list, hist the allocated tags in
  // allocation order (front = oldest, the next to be committed and freed).
  int fl[$];
  int hist[$];
  bit m_ovf;
  int n_alloc_total;

  function automatic void model_reset();
    fl.delete();
    hist.delete();
    for (int k = 0; k < DEPTH; k++) fl.push_back(ARCH_COUNT + k);
    m_ovf = 1'b0;
    n_alloc_total = 0;
  endfunction

  function automatic int popcount(input logic [3:0] m);
    int c = 0;
    for (int i = 0; i < 4; i++) c += int'(m[i]);
    return c;
  endfunction

  typedef struct {
    logic           gnt;
    logic [3:0]     req;
    logic [4*W-1:0] tags;
  } exp_t;

  exp_t exp_q[$];

  task automatic cycle(input logic ce, input logic [3:0] req, input logic [3:0] fen,
                       input logic sq, input int sc,
                       output logic g_seen, output logic [4*W-1:0] t_seen);
    exp_t e;
    exp_t got;
    int   p, k, nreq, nfree, wide;
    int   ftags[$];
    @(negedge clk);
    clk_en     = ce;
    alloc_req  = req;
    free_en    = fen;
    squash_en  = sq;
    squash_cnt = CNT_WIDTH'(sc);
    free_tag   = '0;
    k = 0;
    for (int j = 0; j < 4; j++) begin
      if (fen[j]) begin
        ftags.push_back((k < hist.size()) ? hist[k] : 0);
        free_tag[j*W +: W] = W'(ftags[k]);
        k++;
      end
    end
    nfree  = k;
    nreq   = popcount(req);
    e.req  = req;
    e.gnt  = ce && !sq && (nreq != 0) && (fl.size() >= nreq);
    e.tags = '0;
    p = 0;
    for (int i = 0; i < 4; i++) begin
      if (req[i]) begin
        if (p < fl.size()) e.tags[i*W +: W] = W'(fl[p]);
        p++;
      end
    end
    exp_q.push_back(e);

    #2;
    got    = exp_q.pop_front();
    g_seen = alloc_gnt;
    t_seen = alloc_tag;
    check("alloc_gnt", int'(alloc_gnt), int'(got.gnt));
    if (got.gnt) begin
      for (int i = 0; i < 4; i++) begin
        if (got.req[i]) check("alloc_tag", int'(alloc_tag[i*W +: W]), int'(got.tags[i*W +: W]));
      end
    end

    if (ce) begin
      wide = fl.size() - (e.gnt ? nreq : 0) + (sq ? sc : 0) + nfree;
      if (e.gnt) begin
        for (int i = 0; i < nreq; i++) begin
          hist.push_back(fl.pop_front());
          n_alloc_total++;
        end
      end
      if (wide > DEPTH) begin
        m_ovf = 1'b1;
      end else begin
        if (sq) for (int i = 0; i < sc; i++) fl.push_front(hist.pop_back());
        foreach (ftags[i]) begin
          fl.push_back(ftags[i]);
          void'(hist.pop_front());
        end
      end
    end

    @(posedge clk);
    #1;
    check("free_count", int'(free_count), fl.size());
    check("overflow_err", int'(overflow_err), int'(m_ovf));
  endtask

  task automatic do_reset();
    @(negedge clk);
    async_rst = 1'b1;
    clk_en    = 1'b1;
    alloc_req = 4'b1111;
    free_en   = '0;
    free_tag  = '0;
    squash_en = 1'b0;
    squash_cnt = '0;
    #1;
    check("rst_gnt", int'(alloc_gnt), 0);
    check("rst_count", int'(free_count), DEPTH);
    check("rst_ovf", int'(overflow_err), 0);
    check("rst_tag0", int'(alloc_tag[0 +: W]), ARCH_COUNT);
    @(negedge clk);
    async_rst = 1'b0;
    alloc_req = '0;
    model_reset();
  endtask

  typedef struct {
    logic       ce;
    logic [3:0] req;
    logic [3:0] fen;
    logic       sq;
    int         sc;
    logic       gnt;
    int         cnt;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic           g;
    logic [4*W-1:0] t;
    logic [3:0]     rq, fe;

    async_rst = 1'b1;
    clk_en = 1'b0; alloc_req = '0; free_en = '0; free_tag = '0;
    squash_en = 1'b0; squash_cnt = '0;
    model_reset();

    vecs[0] = '{1'b1, 4'b1111, 4'b0000, 1'b0, 0, 1'b1, 92};
    vecs[1] = '{1'b1, 4'b1010, 4'b0000, 1'b0, 0, 1'b1, 90};
    vecs[2] = '{1'b0, 4'b1111, 4'b0001, 1'b0, 0, 1'b0, 90};
    vecs[3] = '{1'b1, 4'b0001, 4'b0000, 1'b1, 5, 1'b0, 95};
    vecs[4] = '{1'b1, 4'b0001, 4'b0000, 1'b0, 0, 1'b1, 94};
    vecs[5] = '{1'b1, 4'b1111, 4'b0000, 1'b1, 0, 1'b0, 94};
    vecs[6] = '{1'b1, 4'b0000, 4'b0001, 1'b0, 0, 1'b0, 95};
    vecs[7] = '{1'b1, 4'b0011, 4'b0001, 1'b0, 0, 1'b1, 94};

    do_reset();
    foreach (vecs[i]) begin
      cycle(vecs[i].ce, vecs[i].req, vecs[i].fen, vecs[i].sq, vecs[i].sc, g, t);
      check("tbl_gnt", int'(g), int'(vecs[i].gnt));
      check("tbl_count", int'(free_count), vecs[i].cnt);
      if (i == 0) check("tbl_tag3", int'(t[3*W +: W]), 35);
      if (i == 1) check("tbl_tag1", int'(t[1*W +: W]), 36);
      if (i == 4) check("tbl_squash_tag", int'(t[0 +: W]), 33);
    end

    // Sparse mask compaction straight from reset.
    do_reset();
    cycle(1'b1, 4'b1010, 4'b0000, 1'b0, 0, g, t);
    check("sparse_tag1", int'(t[1*W +: W]), 32);
    check("sparse_tag3", int'(t[3*W +: W]), 33);
    cycle(1'b1, 4'b0001, 4'b0000, 1'b0, 0, g, t);
    check("sparse_next", int'(t[0 +: W]), 34);

    // Drain to 2, refuse a 3-wide request, then grant it after frees land.
    do_reset();
    for (int i = 0; i < 23; i++) cycle(1'b1, 4'b1111, 4'b0000, 1'b0, 0, g, t);
    cycle(1'b1, 4'b0011, 4'b0000, 1'b0, 0, g, t);
    check("drain_count", int'(free_count), 2);
    cycle(1'b1, 4'b0111, 4'b0011, 1'b0, 0, g, t);
    check("drain_nogrant", int'(g), 0);
    check("drain_refill", int'(free_count), 4);
    cycle(1'b1, 4'b0111, 4'b0000, 1'b0, 0, g, t);
    check("drain_grant", int'(g), 1);
    check("drain_after", int'(free_count), 1);

    // Squash rewinds five of eight allocated tags.
    do_reset();
    cycle(1'b1, 4'b1111, 4'b0000, 1'b0, 0, g, t);
    cycle(1'b1, 4'b1111, 4'b0000, 1'b0, 0, g, t);
    cycle(1'b1, 4'b0001, 4'b0000, 1'b1, 5, g, t);
    check("squash_block", int'(g), 0);
    check("squash_count", int'(free_count), 93);
    cycle(1'b1, 4'b0001, 4'b0000, 1'b0, 0, g, t);
    check("squash_tag", int'(t[0 +: W]), 35);

    // Random alloc/free traffic long enough for head to wrap past slot 95.
    do_reset();
    for (int i = 0; i < 150; i++) begin
      rq = 4'($urandom_range(0, 15));
      fe = 4'($urandom_range(0, 15));
      while (popcount(fe) > hist.size()) fe = fe & 4'(fe - 4'd1);
      cycle(1'b1, rq, fe, 1'b0, 0, g, t);
    end
    check("wrap_crossed", int'(n_alloc_total > DEPTH), 1);

    // Overflow: freeing into a full list sets the sticky flag.
    do_reset();
    cycle(1'b1, 4'b0000, 4'b0001, 1'b0, 0, g, t);
    check("ovf_set", int'(overflow_err), 1);
    check("ovf_count", int'(free_count), 96);
    for (int i = 0; i < 3; i++) cycle(1'b1, 4'b0001, 4'b0000, 1'b0, 0, g, t);
    check("ovf_sticky", int'(overflow_err), 1);

    // Reset mid-operation restores the initial list immediately.
    cycle(1'b1, 4'b1111, 4'b0000, 1'b0, 0, g, t);
    do_reset();
    cycle(1'b1, 4'b0001, 4'b0000, 1'b0, 0, g, t);
    check("post_rst_tag", int'(t[0 +: W]), 32);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/rename_free_list.md
Name: rename_free_list

Overview:
- Allocator/scheduler for the virtual register tags that the rename map table stores.
- Holds the unmapped virtual tags in a circular FIFO, hands out up to ALLOC_PORTS tags per cycle to rename, and takes back up to FREE_PORTS tags per cycle from commit.
- Supports a squash rewind that returns speculatively allocated tags.
- Sits between decode/rename (consumer) and commit (producer); its grant gates map-table wr_en.

Parameters:
- ARCH_COUNT, 32, architectural registers; tags 0..ARCH_COUNT-1 are never in the list at reset.
- VIRT_COUNT, 128, total virtual tags.
- VIRT_ADDR_WIDTH, $clog2(VIRT_COUNT), tag width.
- ALLOC_PORTS, 4, allocation requesters per cycle.
- FREE_PORTS, 4, tags returned per cycle.
- DEPTH, VIRT_COUNT-ARCH_COUNT, FIFO entries (96, not a power of two).
- PTR_WIDTH, $clog2(DEPTH), head/tail width.
- CNT_WIDTH, $clog2(DEPTH+1), occupancy width.

Ports:
- clk  in  1  clock
- async_rst  in  1  asynchronous active-high reset
- clk_en  in  1  global stall; when 0 no state changes
- alloc_req  in  ALLOC_PORTS  per-port request bitmask
- alloc_gnt  out  1  all-or-nothing grant for this cycle's mask
- alloc_tag  out  VIRT_ADDR_WIDTH x ALLOC_PORTS  tag for each requesting port
- free_en  in  FREE_PORTS  per-port tag-return valid
- free_tag  in  VIRT_ADDR_WIDTH x FREE_PORTS  returned tags
- squash_en  in  1  rewind request
- squash_cnt  in  CNT_WIDTH  number of tags to return by rewinding head
- free_count  out  CNT_WIDTH  registered occupancy
- overflow_err  out  1  sticky error flag

Behaviour:
- Reset (async, rst=1):
  - head=0, tail=0, free_count=DEPTH, overflow_err=0.
  - storage[k]=ARCH_COUNT+k for every k.
  - alloc_gnt=0 while reset is asserted.
- Circular pointers: head is the next tag to hand out; tail is the next write slot. Advance is a modular add (wrap at DEPTH, not 2^PTR_WIDTH).
- Let n_req = popcount(alloc_req) and n_free = popcount(free_en).
- Grant (combinational):
  - alloc_gnt = clk_en & !squash_en & (n_req != 0) & (free_count >= n_req).
  - Partial grants are never issued.
- Tag compaction: alloc_tag[i] = storage[(head + popcount(alloc_req[i-1:0])) mod DEPTH]. Value is don't-care when alloc_req[i]=0. Tags are valid in the same cycle as the request (0-cycle latency).
- On posedge with clk_en=1:
  - If alloc_gnt: head += n_req.
  - If squash_en: head -= squash_cnt (mod DEPTH). Squashed tags are still in storage, so no write is needed. Squash has priority over alloc; alloc is blocked that cycle.
  - Frees: free port j writes storage[(tail + popcount(free_en[j-1:0])) mod DEPTH] = free_tag[j]; then tail += n_free.
  - free_count_next = free_count - (alloc_gnt ? n_req : 0) + (squash_en ? squash_cnt : 0) + n_free.
- Freed tags are not allocatable in the cycle they arrive; they become visible next cycle. The grant uses only the registered free_count.
- Overflow: if free_count_next would exceed DEPTH, set overflow_err (sticky until reset). In that cycle, drop all frees and the squash; alloc still applies.
- Underflow is impossible given the grant rule.
- squash_cnt=0 with squash_en=1 is a legal no-op rewind but still blocks alloc.
- Every value of clk_en=0 freezes all state. Outputs stay combinationally consistent with the frozen state, except alloc_gnt, which is 0.
- Reset asserted mid-operation restores the initial contents immediately; in-flight frees are lost by design.

Decomposition:
- Shared package rename_pkg holds ARCH_COUNT, VIRT_COUNT, widths, and the typedef virt_tag_t. It is also used by the map table.
- One sub-module, prefix_popcount: N-bit mask to per-bit exclusive prefix counts plus total. It is instantiated twice (alloc side and free side).
- Modular pointer add/sub is a package function.

Test Plan:
- Reset -> free_count=96, overflow_err=0. Request mask 4'b1111 -> alloc_gnt=1, tags 32,33,34,35. Next cycle free_count=92.
- Mask 4'b1010 after reset -> alloc_gnt=1, alloc_tag[1]=32, alloc_tag[3]=33. Next request gets 34.
- Drain to free_count=2. Mask 4'b0111 -> alloc_gnt=0, no state change. Same cycle free 2 tags -> next cycle free_count=4 and the 3-request is granted.
- Allocate 8 tags, then squash_en with squash_cnt=5 while alloc_req=4'b0001 -> alloc_gnt=0. Next cycle free_count=93 and the next allocation returns tag 35.
- Wrap-around: cycle enough alloc/free pairs that head crosses index 95. Tags come out in free order across the wrap (storage[95] then storage[0]).
- From reset (full), free_en=4'b0001 -> overflow_err=1 next cycle, free_count stays 96, flag holds until async_rst.
